mem_ctrl: RTL

Memory access controller for the 16-bit CPU: sequences the asynchronous SRAM's active-low chip-select, output-enable and write-enable strobes. It arbitrates between two requesters on the shared memory port:
- the instruction-fetch path (PC/IR side);
- the data-access path (microsequencer load/store).

It latches each request's address and write data, holds the SRAM control strobes through setup, access and hold phases, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_wait_counter.sv | 36 +++
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the SRAM access controller: FSM state encoding, requester IDs
// and the round-robin arbitration rule.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } mc_state_e;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_DATA  = 1'b1
   } mc_req_e;

   // On a tie the requester that did not win last time gets the port.
   function automatic mc_req_e pick_requester(input logic fetch_req, input logic data_req,
                                              input mc_req_e last_grant);
      mc_req_e winner;
      winner = REQ_FETCH;
      if (fetch_req && data_req) begin
         if (last_grant == REQ_FETCH) begin
            winner = REQ_DATA;
         end else begin
            winner = REQ_FETCH;
         end
      end else if (data_req) begin
         winner = REQ_DATA;
      end
      return winner;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing the OE/WE strobe; 'last' flags the final wait cycle.
module mem_wait_counter #(
   parameter int WAIT_STATES = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic last
);

   localparam int CNT_W = $clog2(WAIT_STATES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = CNT_W'(WAIT_STATES);
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/mem_ctrl.sv
// Asynchronous SRAM controller: arbitrates fetch and data requesters and sequences
// CS/OE/WE through setup, access and hold phases. Every output comes straight from a flop.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetchReq,
   input  logic [ADDR_W-1:0] fetchAddr,
   output logic              fetchAck,
   input  logic              dataReq,
   input  logic              dataWrite,
   input  logic [ADDR_W-1:0] dataAddr,
   input  logic [DATA_W-1:0] dataWData,
   output logic              dataAck,
   output logic [DATA_W-1:0] rdData,
   output logic              busy,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memDataOut,
   output logic              memDataOE,
   input  logic [DATA_W-1:0] memDataIn,
   output logic              memNotCS,
   output logic              memNotOE,
   output logic              memNotWE
);

   if (WAIT_STATES < 1) begin : g_bad_wait_states
      $error("mem_ctrl: WAIT_STATES must be at least 1");
   end

   mc_state_e         state_q, state_d;
   mc_req_e           last_grant_q, last_grant_d;
   mc_req_e           grant_q, grant_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              not_cs_q, not_cs_d;
   logic              not_oe_q, not_oe_d;
   logic              not_we_q, not_we_d;
   logic              data_oe_q, data_oe_d;
   logic              fetch_ack_q, fetch_ack_d;
   logic              data_ack_q, data_ack_d;
   logic              busy_q, busy_d;
   logic              wait_last;

   mem_wait_counter #(
      .WAIT_STATES(WAIT_STATES)
   ) u_wait (
      .clock(clock),
      .reset(reset),
      .load (state_q == ST_SETUP),
      .dec  (state_q == ST_ACCESS),
      .last (wait_last)
   );

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      grant_d        = grant_q;
      write_d        = write_q;
      mem_addr_d     = mem_addr_q;
      mem_data_out_d = mem_data_out_q;
      rd_data_d      = rd_data_q;

      case (state_q)
         ST_IDLE: begin
            if (fetchReq || dataReq) begin
               grant_d      = pick_requester(fetchReq, dataReq, last_grant_q);
               last_grant_d = grant_d;
               state_d      = ST_SETUP;
               if (grant_d == REQ_DATA) begin
                  write_d    = dataWrite;
                  mem_addr_d = dataAddr;
                  if (dataWrite) begin
                     mem_data_out_d = dataWData;
                  end
               end else begin
                  write_d    = 1'b0;
                  mem_addr_d = fetchAddr;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (wait_last) begin
               state_d = ST_HOLD;
               if (!write_q) begin
                  rd_data_d = memDataIn;
               end
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes and acks are decoded from the next state so they register with it.
      busy_d      = (state_d != ST_IDLE);
      not_cs_d    = !busy_d;
      not_oe_d    = !((state_d == ST_ACCESS) && !write_d);
      not_we_d    = !((state_d == ST_ACCESS) && write_d);
      data_oe_d   = busy_d && write_d;
      fetch_ack_d = (state_d == ST_HOLD) && (grant_d == REQ_FETCH);
      data_ack_d  = (state_d == ST_HOLD) && (grant_d == REQ_DATA);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         last_grant_q   <= REQ_FETCH;
         grant_q        <= REQ_FETCH;
         write_q        <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_out_q <= '0;
         rd_data_q      <= '0;
         not_cs_q       <= 1'b1;
         not_oe_q       <= 1'b1;
         not_we_q       <= 1'b1;
         data_oe_q      <= 1'b0;
         fetch_ack_q    <= 1'b0;
         data_ack_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         grant_q        <= grant_d;
         write_q        <= write_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_out_q <= mem_data_out_d;
         rd_data_q      <= rd_data_d;
         not_cs_q       <= not_cs_d;
         not_oe_q       <= not_oe_d;
         not_we_q       <= not_we_d;
         data_oe_q      <= data_oe_d;
         fetch_ack_q    <= fetch_ack_d;
         data_ack_q     <= data_ack_d;
         busy_q         <= busy_d;
      end
   end

   assign fetchAck   = fetch_ack_q;
   assign dataAck    = data_ack_q;
   assign rdData     = rd_data_q;
   assign busy       = busy_q;
   assign memAddr    = mem_addr_q;
   assign memDataOut = mem_data_out_q;
   assign memDataOE  = data_oe_q;
   assign memNotCS   = not_cs_q;
   assign memNotOE   = not_oe_q;
   assign memNotWE   = not_we_q;

endmodule
